alarm_sequencer: RTL
====================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter SNOOZE_MIN, default 5, snooze length in minutes (legal 1..15).
REQ-002 Parameter RING_TIMEOUT_S, default 60, seconds of ringing before auto-stop (legal 1..255).
REQ-003 clk  input  1  system clock, 31.5 MHz pixel clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_1hz  input  1  one-cycle pulse once per second, coincident with the seconds increment.
REQ-006 hours  input  4  current hour, 0..11.
REQ-007 minutes  input  6  current minute, 0..59.
REQ-008 seconds  input  6  current second, 0..59.
REQ-009 al_hours  input  4  alarm hour, 0..11.
REQ-010 al_minutes  input  6  alarm minute, 0..59.
REQ-011 toggle_pulse  input  1  debounced one-cycle arm/disarm/dismiss request.
REQ-012 snooze_pulse  input  1  debounced one-cycle snooze request.
REQ-013 tone_in  input  1  buzzer-frequency square wave.
REQ-014 buzzer_out  output  1  gated tone to external buzzer driver.
REQ-015 al_on  output  1  alarm armed indicator (state != OFF).
REQ-016 ringing  output  1  high in RINGING.
REQ-017 snoozing  output  1  high in SNOOZE.
REQ-018 bell_visible  output  1  enable for the bell icon overlay.

Function
REQ-019 FSM states OFF, ARMED, RINGING, SNOOZE; all transitions registered, visible on outputs the cycle after the causing input.
REQ-020 Event priority within one cycle: toggle_pulse > snooze_pulse > tick_1hz-driven transitions.
REQ-021 OFF: toggle_pulse -> ARMED; all else ignored.
REQ-022 ARMED: toggle_pulse -> OFF; tick_1hz with hours==al_hours, minutes==al_minutes, seconds==0 -> RINGING.
REQ-023 RINGING entry: ring_cnt cleared to 0, beat set to 1.
REQ-024 RINGING: each tick_1hz increments ring_cnt and inverts beat; tick where ring_cnt==RING_TIMEOUT_S-1 -> ARMED.
REQ-025 RINGING: toggle_pulse -> OFF (dismiss and disarm); snooze_pulse -> SNOOZE, snooze_cnt loaded with SNOOZE_MIN*60.
REQ-026 SNOOZE: each tick_1hz decrements snooze_cnt; tick where snooze_cnt==1 -> RINGING (REQ-023 entry); toggle_pulse -> OFF; snooze_pulse ignored.
REQ-027 snooze_cnt 10 bits unsigned, never wraps below 0; ring_cnt 8 bits, never exceeds RING_TIMEOUT_S-1.
REQ-028 Alarm match evaluated only in ARMED; time changes from adjust buttons with no tick do not trigger.
REQ-029 buzzer_out = tone_in AND ringing AND beat, combinational from tone_in only; state terms registered.
REQ-030 bell_visible = 1 in ARMED and SNOOZE, = beat in RINGING, = 0 in OFF.
REQ-031 snooze_pulse in OFF or ARMED has no effect.

Reset
REQ-032 reset forces state OFF, ring_cnt 0, snooze_cnt 0, beat 0 on the next clk edge, overriding all same-cycle inputs.
REQ-033 During and after reset: buzzer_out 0, al_on 0, ringing 0, snoozing 0, bell_visible 0.
REQ-034 reset asserted in RINGING or SNOOZE aborts immediately; no ring resumes after release.

Configuration
REQ-035 Macro ALARM_SNOOZE_EN compiles the snooze feature in.
REQ-036 With ALARM_SNOOZE_EN defined: behaviour per REQ-025/026.
REQ-037 Without ALARM_SNOOZE_EN: SNOOZE state and snooze_cnt absent, snooze_pulse ignored, snoozing tied 0; all other behaviour unchanged.

Verification
REQ-038 Reset, toggle_pulse, al 3:15, time 3:14:59, tick -> seconds 0 at 3:15 tick -> ringing=1 next cycle, buzzer_out follows tone_in for 1 s, 0 for next 1 s.
REQ-039 RINGING with RING_TIMEOUT_S=4, four ticks, no buttons -> state ARMED after 4th tick, buzzer_out 0, al_on 1.
REQ-040 RINGING, snooze_pulse, SNOOZE_MIN=1 -> snoozing=1; 60 ticks later ringing=1 with beat=1.
REQ-041 toggle_pulse and snooze_pulse same cycle in RINGING -> OFF, al_on 0, snoozing 0.
REQ-042 reset mid-SNOOZE then re-arm -> OFF then ARMED, no ring until next match at seconds==0.
REQ-043 Build without ALARM_SNOOZE_EN, snooze_pulse in RINGING -> stays RINGING, snoozing 0.

Source files
------------

// File: rtl/alarm_sequencer_if.sv
// Alarm sequencer signal bundle: time-of-day, alarm setting, button pulses,
// buzzer tone and the status/drive outputs.
// master = time-keeping/button side, slave = alarm_sequencer.
interface alarm_sequencer_if;
    logic       tick_1hz;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [3:0] al_hours;
    logic [5:0] al_minutes;
    logic       toggle_pulse;
    logic       snooze_pulse;
    logic       tone_in;
    logic       buzzer_out;
    logic       al_on;
    logic       ringing;
    logic       snoozing;
    logic       bell_visible;

    modport master (
        output tick_1hz, hours, minutes, seconds, al_hours, al_minutes,
        output toggle_pulse, snooze_pulse, tone_in,
        input  buzzer_out, al_on, ringing, snoozing, bell_visible
    );

    modport slave (
        input  tick_1hz, hours, minutes, seconds, al_hours, al_minutes,
        input  toggle_pulse, snooze_pulse, tone_in,
        output buzzer_out, al_on, ringing, snoozing, bell_visible
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm clock sequencer: OFF / ARMED / RINGING / SNOOZE state machine.
// The snooze feature (SNOOZE state, snooze counter, snooze_pulse handling)
// is compiled in only when the macro ALARM_SNOOZE_EN is defined; the default
// build has no snooze and ties snoozing low.
module alarm_sequencer #(
    parameter int SNOOZE_MIN     = 5,   // snooze length in minutes, 1..15
    parameter int RING_TIMEOUT_S = 60   // ring length before auto-stop, 1..255
) (
    input  logic               clk,
    input  logic               reset,
    alarm_sequencer_if.slave   bus
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
`else
    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2
    } state_t;
`endif

    // Last ring_cnt value; the tick seen at this count ends the ring.
    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);

    state_t     state_reg, state_next;
    logic [7:0] ring_cnt_reg, ring_cnt_next;
    logic       beat_reg, beat_next;
    logic       bell_next;
    logic       al_on_reg, ringing_reg, bell_reg;
    logic       alarm_match;

`ifdef ALARM_SNOOZE_EN
    logic [9:0] snooze_cnt_reg, snooze_cnt_next;
    logic       snoozing_reg;
`else
    // Snooze button has no function in this build.
    logic       unused_snooze_pulse;
    assign unused_snooze_pulse = bus.snooze_pulse;
`endif

    // Alarm fires only on a real seconds tick landing on hh:mm:00, so
    // adjusting the clock onto the alarm time never triggers it.
    assign alarm_match = bus.tick_1hz
                      && (bus.hours   == bus.al_hours)
                      && (bus.minutes == bus.al_minutes)
                      && (bus.seconds == 6'd0);

    // Next-state logic; toggle beats snooze beats tick-driven transitions.
    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        beat_next     = beat_reg;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_next = snooze_cnt_reg;
`endif
        case (state_reg)
            ST_OFF: begin
                if (bus.toggle_pulse) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.toggle_pulse) begin
                    state_next = ST_OFF;
                end else if (alarm_match) begin
                    state_next    = ST_RINGING;
                    ring_cnt_next = 8'd0;
                    beat_next     = 1'b1;
                end
            end
            ST_RINGING: begin
                if (bus.toggle_pulse) begin
                    state_next    = ST_OFF;
                    ring_cnt_next = 8'd0;
                    beat_next     = 1'b0;
                end
`ifdef ALARM_SNOOZE_EN
                else if (bus.snooze_pulse) begin
                    state_next      = ST_SNOOZE;
                    ring_cnt_next   = 8'd0;
                    beat_next       = 1'b0;
                    snooze_cnt_next = SNOOZE_LOAD;
                end
`endif
                else if (bus.tick_1hz) begin
                    if (ring_cnt_reg >= RING_LAST) begin
                        state_next    = ST_ARMED;
                        ring_cnt_next = 8'd0;
                        beat_next     = 1'b0;
                    end else begin
                        ring_cnt_next = ring_cnt_reg + 8'd1;
                        beat_next     = ~beat_reg;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (bus.toggle_pulse) begin
                    state_next      = ST_OFF;
                    snooze_cnt_next = 10'd0;
                end else if (bus.tick_1hz) begin
                    // <= 1 rather than == 1 so the counter can never wrap.
                    if (snooze_cnt_reg <= 10'd1) begin
                        state_next      = ST_RINGING;
                        ring_cnt_next   = 8'd0;
                        beat_next       = 1'b1;
                        snooze_cnt_next = 10'd0;
                    end else begin
                        snooze_cnt_next = snooze_cnt_reg - 10'd1;
                    end
                end
            end
`endif
            default: begin
                state_next    = ST_OFF;
                ring_cnt_next = 8'd0;
                beat_next     = 1'b0;
            end
        endcase

        case (state_next)
            ST_ARMED:   bell_next = 1'b1;
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE:  bell_next = 1'b1;
`endif
            ST_RINGING: bell_next = beat_next;
            default:    bell_next = 1'b0;
        endcase
    end

    // State, counters and status outputs all register together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_OFF;
            ring_cnt_reg <= 8'd0;
            beat_reg     <= 1'b0;
            al_on_reg    <= 1'b0;
            ringing_reg  <= 1'b0;
            bell_reg     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_reg <= 10'd0;
            snoozing_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            beat_reg     <= beat_next;
            al_on_reg    <= (state_next != ST_OFF);
            ringing_reg  <= (state_next == ST_RINGING);
            bell_reg     <= bell_next;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_reg <= snooze_cnt_next;
            snoozing_reg   <= (state_next == ST_SNOOZE);
`endif
        end
    end

    // Tone passes straight through; only the gating terms are registered.
    assign bus.buzzer_out   = bus.tone_in & ringing_reg & beat_reg;
    assign bus.al_on        = al_on_reg;
    assign bus.ringing      = ringing_reg;
    assign bus.bell_visible = bell_reg;
`ifdef ALARM_SNOOZE_EN
    assign bus.snoozing     = snoozing_reg;
`else
    assign bus.snoozing     = 1'b0;
`endif

endmodule
